// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: first-word-fall-through byte FIFO feeding the UART TX serialiser.
// Optional feature macro: UART_TX_FIFO_DROP_EN (drop-on-full with sticky ovf flag
// instead of backpressure). Default build: backpressure, no ovf/ovf_clr ports.
module uart_tx_fifo #(
    parameter  int unsigned DATA_W = 8,
    parameter  int unsigned DEPTH  = 16,
    localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_valid,
    output logic              wr_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [ADDR_W:0]   level
`ifdef UART_TX_FIFO_DROP_EN
    ,
    output logic              ovf,
    input  logic              ovf_clr
`endif
);

    localparam int unsigned LVL_W = ADDR_W + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [LVL_W-1:0]  level_q;
    logic [LVL_W-1:0]  level_nxt;
    logic              rd_valid_q;
    logic              not_full_q;
    logic              wr_fire;
    logic              rd_fire;

    // A full FIFO refuses writes even when a read happens in the same cycle.
    assign wr_fire = wr_valid && not_full_q;
    assign rd_fire = rd_ready && rd_valid_q;

    // Occupancy update: +1 write-only, -1 read-only, otherwise unchanged.
    always_comb begin
        level_nxt = level_q;
        case ({wr_fire, rd_fire})
            2'b10:   level_nxt = level_q + LVL_W'(1);
            2'b01:   level_nxt = level_q - LVL_W'(1);
            default: level_nxt = level_q;
        endcase
    end

    // Storage array; contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers, level and the status flags derived from the next level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level_q    <= '0;
            rd_valid_q <= 1'b0;
            not_full_q <= 1'b1;
        end else begin
            if (wr_fire) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end
            if (rd_fire) begin
                rd_ptr <= rd_ptr + ADDR_W'(1);
            end
            level_q    <= level_nxt;
            rd_valid_q <= (level_nxt != '0);
            not_full_q <= (level_nxt != LVL_W'(DEPTH));
        end
    end

    // Head of queue is presented straight from the registered read pointer.
    assign rd_data  = mem[rd_ptr];
    assign rd_valid = rd_valid_q;
    assign level    = level_q;

`ifdef UART_TX_FIFO_DROP_EN
    logic ovf_q;

    // Sticky overflow: a write offered while full is dropped and sets the flag;
    // a set in the same cycle as a clear wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (wr_valid && !not_full_q) begin
            ovf_q <= 1'b1;
        end else if (ovf_clr) begin
            ovf_q <= 1'b0;
        end
    end

    assign ovf      = ovf_q;
    assign wr_ready = 1'b1;
`else
    assign wr_ready = not_full_q;
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Testbench for uart_tx_fifo: queue-based reference model plus directed scenarios.
// Build with +define+UART_TX_FIFO_DROP_EN to exercise the drop-on-full variant.
module tb_uart_tx_fifo;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned DEPTH  = 16;
    localparam int unsigned ADDR_W = $clog2(DEPTH);

    logic              clk;
    logic              rst;
    logic [DATA_W-1:0] wr_data;
    logic              wr_valid;
    logic              wr_ready;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              rd_ready;
    logic [ADDR_W:0]   level;
`ifdef UART_TX_FIFO_DROP_EN
    logic              ovf;
    logic              ovf_clr;
    bit                ovf_m;
`endif

    int total;
    int bad;

    logic [7:0] q[$];        // model contents, head at q[0]
    logic [7:0] out_log[$];  // bytes the model saw leave the FIFO

    uart_tx_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_data  (wr_data),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .rd_ready (rd_ready),
        .level    (level)
`ifdef UART_TX_FIFO_DROP_EN
        ,
        .ovf      (ovf),
        .ovf_clr  (ovf_clr)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Reference model: a byte queue; acceptance decided from pre-edge occupancy.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
`ifdef UART_TX_FIFO_DROP_EN
            ovf_m = 1'b0;
`endif
        end else begin
            automatic bit acc_r = rd_ready && (q.size() != 0);
            automatic bit acc_w = wr_valid && (q.size() < DEPTH);
`ifdef UART_TX_FIFO_DROP_EN
            if (wr_valid && q.size() == DEPTH) ovf_m = 1'b1;
            else if (ovf_clr)                  ovf_m = 1'b0;
`endif
            if (acc_r) out_log.push_back(q.pop_front());
            if (acc_w) q.push_back(wr_data);
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (!rst) begin
            chk("level", 32'(level), 32'(q.size()));
            chk("rd_valid", 32'(rd_valid), 32'(q.size() != 0));
            if (q.size() != 0) chk("rd_data", 32'(rd_data), 32'(q[0]));
`ifdef UART_TX_FIFO_DROP_EN
            chk("wr_ready", 32'(wr_ready), 32'd1);
            chk("ovf", 32'(ovf), 32'(ovf_m));
`else
            chk("wr_ready", 32'(wr_ready), 32'(q.size() != DEPTH));
`endif
        end
    end

    task automatic drain(input int budget);
        rd_ready = 1'b1;
        for (int g = 0; g < budget && q.size() != 0; g++) cyc();
        rd_ready = 1'b0;
        chk("drain_empty", 32'(q.size()), 32'd0);
    endtask

    initial begin
        logic [7:0] hello [7];
        int idx;
        bit rdy;
        total = 0;
        bad = 0;
        rst = 1'b1;
        wr_data = '0;
        wr_valid = 1'b0;
        rd_ready = 1'b0;
`ifdef UART_TX_FIFO_DROP_EN
        ovf_clr = 1'b0;
`endif
        hello[0] = 8'h48; hello[1] = 8'h65; hello[2] = 8'h6C; hello[3] = 8'h6C;
        hello[4] = 8'h6F; hello[5] = 8'h0D; hello[6] = 8'h0A;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_rd_valid", 32'(rd_valid), 32'd0);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_wr_ready", 32'(wr_ready), 32'd1);
`ifdef UART_TX_FIFO_DROP_EN
        chk("rst_ovf", 32'(ovf), 32'd0);
`endif
        #1 rst = 1'b0;
        cyc();

        // 1: single byte, one-cycle write-to-output latency, held while not taken
        wr_valid = 1'b1; wr_data = 8'h48;
        cyc();
        wr_valid = 1'b0;
        for (int c = 0; c < 10; c++) begin
            chk("t1_rd_valid", 32'(rd_valid), 32'd1);
            chk("t1_rd_data", 32'(rd_data), 32'h48);
            chk("t1_level", 32'(level), 32'd1);
            cyc();
        end
        drain(5);

`ifndef UART_TX_FIFO_DROP_EN
        // 2: burst of 20 into a 16-deep FIFO with consumer idle, then drain
        out_log.delete();
        idx = 0;
        for (int c = 0; c < 20; c++) begin
            wr_valid = 1'b1; wr_data = 8'(idx);
            @(negedge clk); rdy = wr_ready;
            cyc();
            if (rdy) idx++;
        end
        chk("t2_accepted", 32'(idx), 32'd16);
        chk("t2_level_full", 32'(level), 32'd16);
        chk("t2_wr_ready_full", 32'(wr_ready), 32'd0);
        rd_ready = 1'b1;
        for (int g = 0; g < 100 && idx < 20; g++) begin
            wr_data = 8'(idx);
            @(negedge clk); rdy = wr_ready;
            cyc();
            if (rdy) idx++;
        end
        wr_valid = 1'b0;
        drain(40);
        chk("t2_out_count", 32'(out_log.size()), 32'd20);
        foreach (out_log[i]) chk("t2_order", 32'(out_log[i]), 32'(i));
`endif

        // 3: steady state at level 5 with simultaneous read and write
        out_log.delete();
        for (int c = 0; c < 5; c++) begin
            wr_valid = 1'b1; wr_data = 8'(8'h80 + c);
            cyc();
        end
        rd_ready = 1'b1;
        for (int c = 5; c < 45; c++) begin
            wr_data = 8'(8'h80 + c);
            cyc();
        end
        wr_valid = 1'b0; rd_ready = 1'b0;
        chk("t3_level", 32'(level), 32'd5);
        chk("t3_out_count", 32'(out_log.size()), 32'd40);
        foreach (out_log[i]) chk("t3_order", 32'(out_log[i]), 32'(8'h80 + i));
        drain(10);

        // 4: slow consumer pulling "Hello\r\n" once every 100 cycles
        out_log.delete();
        for (int c = 0; c < 7; c++) begin
            wr_valid = 1'b1; wr_data = hello[c];
            cyc();
        end
        wr_valid = 1'b0;
        for (int p = 0; p < 7; p++) begin
            repeat (99) cyc();
            chk("t4_gap", 32'(out_log.size()), 32'(p));
            rd_ready = 1'b1;
            cyc();
            rd_ready = 1'b0;
        end
        chk("t4_out_count", 32'(out_log.size()), 32'd7);
        for (int i = 0; i < 7 && i < out_log.size(); i++) chk("t4_byte", 32'(out_log[i]), 32'(hello[i]));
        chk("t4_level", 32'(level), 32'd0);
        chk("t4_rd_valid", 32'(rd_valid), 32'd0);

        // 5: asynchronous reset in the middle of a burst
        for (int c = 0; c < 9; c++) begin
            wr_valid = 1'b1; wr_data = 8'(8'hC0 + c);
            cyc();
        end
        chk("t5_level9", 32'(level), 32'd9);
        #2 rst = 1'b1;
        #1;
        chk("t5_rd_valid", 32'(rd_valid), 32'd0);
        chk("t5_level", 32'(level), 32'd0);
        chk("t5_wr_ready", 32'(wr_ready), 32'd1);
        wr_valid = 1'b0;
        @(negedge clk);
        #1 rst = 1'b0;
        cyc();
        wr_valid = 1'b1; wr_data = 8'h5A;
        cyc();
        wr_valid = 1'b0;
        chk("t5_first_out", 32'(rd_data), 32'h5A);
        chk("t5_level1", 32'(level), 32'd1);
        drain(5);

`ifdef UART_TX_FIFO_DROP_EN
        // 6: write while full is dropped and flags overflow until cleared
        out_log.delete();
        for (int c = 0; c < 16; c++) begin
            wr_valid = 1'b1; wr_data = 8'(8'h10 + c);
            cyc();
        end
        wr_data = 8'hAA;
        cyc();
        wr_valid = 1'b0;
        chk("t6_ovf_set", 32'(ovf), 32'd1);
        chk("t6_level", 32'(level), 32'd16);
        drain(40);
        chk("t6_out_count", 32'(out_log.size()), 32'd16);
        foreach (out_log[i]) chk("t6_order", 32'(out_log[i]), 32'(8'h10 + i));
        chk("t6_ovf_sticky", 32'(ovf), 32'd1);
        ovf_clr = 1'b1;
        cyc();
        ovf_clr = 1'b0;
        chk("t6_ovf_clr", 32'(ovf), 32'd0);
`endif

        repeat (3) cyc();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
